// File: rtl/timer_pkg.sv
// Shared definitions for the bus-mapped countdown timer: FSM states,
// register offsets, CTRL bit positions, MODE codes and byte-lane merge.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  // Word offsets, as selected by addr[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_PSC    = 2'd3;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Decrement tick generator for bus_timer; only built with TIMER_PRESCALER_EN.
// Emits a registered one-cycle tick every psc+1 cycles while run is high.
`ifdef TIMER_PRESCALER_EN
module timer_prescaler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] psc,
  output logic        tick
);

  logic [31:0] pc_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pc_q <= '0;
      tick <= 1'b0;
    end else if (run) begin
      if (pc_q == psc) begin
        pc_q <= '0;
        tick <= 1'b1;
      end else begin
        pc_q <= pc_q + 32'd1;
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/bus_timer.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes and masked irq.
// Optional PSC register and prescaled decrement when TIMER_PRESCALER_EN is defined.
module bus_timer
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        flag_q;

  logic        hit, wr, wr_ctrl, wr_preset;
  logic [1:0]  sel;
  logic        en, reload, tick;
  logic        load, dec, set_flag, int_exit;
  logic        unused_addr_lsbs;

  assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
  assign sel       = addr[3:2];
  assign wr        = hit && (|byteen);
  assign wr_ctrl   = wr && (sel == REG_CTRL);
  assign wr_preset = wr && (sel == REG_PRESET);
  assign unused_addr_lsbs = &{1'b0, addr[1:0]};

  assign en     = ctrl_q[CTRL_EN];
  assign reload = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
  assign irq    = flag_q & ctrl_q[CTRL_IM];

`ifdef TIMER_PRESCALER_EN
  logic [31:0] psc_q;

  always_ff @(posedge clk) begin
    if (reset) psc_q <= '0;
    else if (wr && (sel == REG_PSC)) psc_q <= byte_merge(psc_q, wdata, byteen);
  end

  timer_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (state_q == ST_LOAD),
    .run   (state_q == ST_CNT),
    .psc   (psc_q),
    .tick  (tick)
  );
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (sel)
        REG_CTRL:   rdata = {28'b0, ctrl_q};
        REG_PRESET: rdata = preset_q;
        REG_COUNT:  rdata = count_q;
`ifdef TIMER_PRESCALER_EN
        default:    rdata = psc_q;
`else
        default:    rdata = '0;
`endif
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    dec      = 1'b0;
    set_flag = 1'b0;
    int_exit = 1'b0;
    case (state_q)
      ST_IDLE: if (en) state_d = ST_LOAD;
      ST_LOAD: begin
        load    = 1'b1;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        // Zero is only acted on at a tick, so the last prescaled step is not cut short
        if (!en) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (count_q == '0) begin
            state_d  = ST_INT;
            set_flag = 1'b1;
          end else begin
            dec = 1'b1;
          end
        end
      end
      ST_INT: begin
        int_exit = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      // A bus write to CTRL wins over the one-shot EN clear
      if (wr_ctrl) begin
        if (byteen[0]) ctrl_q <= wdata[3:0];
      end else if (int_exit && !reload) begin
        ctrl_q[CTRL_EN] <= 1'b0;
      end

      if (wr_preset) preset_q <= byte_merge(preset_q, wdata, byteen);

      if (load)     count_q <= preset_q;
      else if (dec) count_q <= count_q - 32'd1;

      if (wr_ctrl)                 flag_q <= 1'b0;
      else if (set_flag)           flag_q <= 1'b1;
      else if (int_exit && reload) flag_q <= 1'b0;
    end
  end

endmodule

// File: doc/bus_timer.md
# bus_timer

Memory-mapped countdown timer on the CPU data bus, downstream of the pipeline's M stage. It consumes the M-stage data address, write data and byte enables, and returns read data combinationally in the same cycle, as the M-stage load path requires. It counts down from a preset value, raises an interrupt request, and supports one-shot and auto-reload modes.

## Interface
- BASE_ADDR, 32'h0000_7F00, 16-byte-aligned base of the register window
- clk  input  1  system clock
- reset  input  1  synchronous, active-high; one clock; sampled on rising edge of clk
- addr  input  32  bus byte address (M-stage data address)
- byteen  input  4  byte write enables; any bit set = write cycle
- wdata  input  32  write data, already lane-aligned by upstream store logic
- rdata  output  32  read data, combinational from addr
- irq  output  1  interrupt request, registered

## Operation
- Hit: addr[31:4]==BASE_ADDR[31:4]. addr[3:2] selects: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved. addr[1:0] ignored.
- Miss: rdata=0, writes ignored.
- CTRL bits: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM (irq mask enable). Bits [31:4] read 0, writes ignored.
- Writes merge per byte lane. Only lanes with byteen set change.
- PRESET: full 32-bit read/write.
- COUNT: read-only. Writes are ignored.
- FSM:
  - IDLE: EN=1 -> LOAD.
  - LOAD: COUNT<=PRESET -> CNT.
  - CNT: EN=0 -> IDLE. Otherwise COUNT==0 -> INT. Otherwise COUNT<=COUNT-1.
  - INT: set irq flag. MODE 00: clear EN, go to IDLE, flag held. MODE 01: go to IDLE with EN kept, flag cleared on the next edge (one-cycle pulse).
- irq = flag & IM.
- Any write to CTRL clears the flag on that edge.
- Simultaneous events:
  - A bus write to CTRL takes priority over the FSM's EN clear in INT.
  - A PRESET write during CNT does not affect the current count; it takes effect at the next LOAD.
  - PRESET=0: LOAD then immediate INT.
- COUNT decrement never wraps. 0 is terminal in CNT.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, state IDLE, flag=0, irq=0. rdata follows register contents (0 when read after reset).
- Reset mid-count returns everything to the reset values on that edge. No pending irq survives.
- Write at edge 0 setting EN=1 with preset P:
  - LOAD at edge 1.
  - COUNT=P at edge 2.
  - COUNT=0 at edge P+2.
  - INT and irq high after edge P+3.
- One-shot: irq stays high until a CTRL write. EN reads 0 after edge P+4.
- Auto-reload: irq high exactly one cycle. Period P+4 cycles.
- rdata has zero latency. A read in the same cycle as a write returns the old value.

## Configuration
- TIMER_PRESCALER_EN defined:
  - Adds PSC register at offset 0xC (32-bit R/W, reset 0).
  - In CNT, COUNT decrements only once every PSC+1 cycles.
  - The prescale counter restarts at LOAD.
- Undefined: offset 0xC reads 0, writes ignored, and COUNT decrements every cycle.

## Structure
- Shared package timer_pkg holds:
  - state encoding: IDLE, LOAD, CNT, INT
  - register offsets
  - CTRL bit positions
  - MODE codes
- Optional sub-module timer_prescaler: tick generator, instantiated only under TIMER_PRESCALER_EN.
- Register file, byte-merge logic and FSM stay in bus_timer.

## Test plan
- Reset, then read 0x7F00, 0x7F04, 0x7F08 -> all return 0; irq=0.
- Write PRESET=3, then CTRL=0x9 (EN, one-shot, IM) -> COUNT reads 3,2,1,0; irq rises 6 edges after the CTRL write and holds; EN reads 0; a CTRL write of 0 drops irq on the next edge.
- CTRL=0xB (auto-reload, IM), PRESET=2 -> irq one-cycle pulses every 6 cycles, at least 3 periods.
- byteen=4'b0010, wdata=0x0000AB00 to PRESET holding 0x11223344 -> PRESET reads 0x1122AB44; a write to COUNT leaves it unchanged; a write to 0x7F10 changes nothing.
- Reset asserted while COUNT=5 in CNT -> next cycle all registers 0, irq=0, state IDLE.
- With TIMER_PRESCALER_EN, PSC=1, PRESET=2 -> COUNT steps every 2 cycles; irq at edge 9 after the CTRL write.
